// File: rtl/floor_pkg.sv
// Shared types and constants for the floor renderer.
package floor_pkg;

  localparam int unsigned TILE_W_DEF = 32;
  localparam int unsigned TILE_H_DEF = 32;
  localparam int unsigned FLOOR_LAT  = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} aux_state_t;

endpackage

// File: rtl/floor_pixel_pipe.sv
// Floor pixel pipeline: tile address arithmetic, valid delay line and RGB output register.
// FLOOR_GRID_EN overlays white on tile row/column 0 for a debug grid.
module floor_pixel_pipe
  import floor_pkg::*;
#(
  parameter int unsigned TILE_W = TILE_W_DEF,
  parameter int unsigned TILE_H = TILE_H_DEF,
  parameter int unsigned ROM_AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_valid_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        scroll_x_i,
  input  logic [9:0]        scroll_y_i,
  output logic [ROM_AW-1:0] vid_addr_o,
  input  rgb12_t            pal_i,
  output rgb12_t            rgb_o,
  output logic              rgb_valid_o
);

  localparam int unsigned XW = $clog2(TILE_W);
  localparam int unsigned YW = $clog2(TILE_H);

  logic [9:0]    sum_x, sum_y;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  logic          unused_hi;

  // Tile sizes are powers of two, so keeping the low bits is the modulo.
  assign sum_x      = draw_x_i + scroll_x_i;
  assign sum_y      = draw_y_i + scroll_y_i;
  assign tx         = sum_x[XW-1:0];
  assign ty         = sum_y[YW-1:0];
  assign unused_hi  = ^{sum_x[9:XW], sum_y[9:YW]};
  assign vid_addr_o = ROM_AW'({ty, tx});

  logic [FLOOR_LAT-2:0] valid_q;
  rgb12_t               rgb_d, rgb_q;
  logic                 rgb_valid_q;

`ifdef FLOOR_GRID_EN
  logic [FLOOR_LAT-2:0] grid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) grid_q <= '0;
    else       grid_q <= {grid_q[FLOOR_LAT-3:0], (tx == '0) || (ty == '0)};
  end

  always_comb begin
    rgb_d = '0;
    if (valid_q[FLOOR_LAT-2]) rgb_d = grid_q[FLOOR_LAT-2] ? rgb12_t'(12'hFFF) : pal_i;
  end
`else
  always_comb begin
    rgb_d = '0;
    if (valid_q[FLOOR_LAT-2]) rgb_d = pal_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      valid_q     <= {valid_q[FLOOR_LAT-3:0], pix_valid_i};
      rgb_q       <= rgb_d;
      rgb_valid_q <= valid_q[FLOOR_LAT-2];
    end
  end

  assign rgb_o       = rgb_q;
  assign rgb_valid_o = rgb_valid_q;

endmodule

// File: rtl/floor_render_ctrl.sv
// Floor render controller: frame-latched scroll, tile ROM arbitration (video first, aux in blank)
// and palette output via floor_pixel_pipe. Optional macro FLOOR_GRID_EN enables a debug grid.
module floor_render_ctrl
  import floor_pkg::*;
#(
  parameter int unsigned TILE_W = TILE_W_DEF,
  parameter int unsigned TILE_H = TILE_H_DEF,
  parameter int unsigned ROM_AW = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  input  logic              scroll_we,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              rgb_valid,
  input  logic              aux_req,
  input  logic [ROM_AW-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_data_valid,
  output logic [3:0]        aux_data
);

  logic [9:0] sx_pend_d, sx_pend_q, sy_pend_d, sy_pend_q;
  logic [9:0] sx_act_d, sx_act_q, sy_act_d, sy_act_q;

  // A write coinciding with frame_start lands in active immediately.
  always_comb begin
    sx_pend_d = scroll_we ? scroll_x : sx_pend_q;
    sy_pend_d = scroll_we ? scroll_y : sy_pend_q;
    sx_act_d  = frame_start ? sx_pend_d : sx_act_q;
    sy_act_d  = frame_start ? sy_pend_d : sy_act_q;
  end

  logic [ROM_AW-1:0] vid_addr;
  rgb12_t            rgb;

  floor_pixel_pipe #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .ROM_AW (ROM_AW)
  ) u_pipe (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .pix_valid_i (pix_valid),
    .draw_x_i    (DrawX),
    .draw_y_i    (DrawY),
    .scroll_x_i  (sx_act_q),
    .scroll_y_i  (sy_act_q),
    .vid_addr_o  (vid_addr),
    .pal_i       ({pal_red, pal_green, pal_blue}),
    .rgb_o       (rgb),
    .rgb_valid_o (rgb_valid)
  );

  assign pal_index = rom_data;
  assign red       = rgb.r;
  assign green     = rgb.g;
  assign blue      = rgb.b;

  aux_state_t        state_d, state_q;
  logic [ROM_AW-1:0] rom_addr_d, rom_addr_q;
  logic              gnt_d, gnt_q, dv_d, dv_q;
  logic [3:0]        aux_data_d, aux_data_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    gnt_d      = 1'b0;
    dv_d       = 1'b0;
    aux_data_d = aux_data_q;
    if (pix_valid) rom_addr_d = vid_addr;
    unique case (state_q)
      IDLE: begin
        if (aux_req && !pix_valid) begin
          state_d    = WAIT;
          gnt_d      = 1'b1;
          rom_addr_d = aux_addr;
        end
      end
      WAIT: state_d = RESP;
      RESP: begin
        aux_data_d = rom_data;
        dv_d       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx_pend_q  <= '0;
      sy_pend_q  <= '0;
      sx_act_q   <= '0;
      sy_act_q   <= '0;
      state_q    <= IDLE;
      rom_addr_q <= '0;
      gnt_q      <= 1'b0;
      dv_q       <= 1'b0;
      aux_data_q <= '0;
    end else begin
      sx_pend_q  <= sx_pend_d;
      sy_pend_q  <= sy_pend_d;
      sx_act_q   <= sx_act_d;
      sy_act_q   <= sy_act_d;
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      gnt_q      <= gnt_d;
      dv_q       <= dv_d;
      aux_data_q <= aux_data_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign aux_gnt        = gnt_q;
  assign aux_data_valid = dv_q;
  assign aux_data       = aux_data_q;

endmodule

// File: tb/tb_floor_render_ctrl.sv
// Self-checking bench for floor_render_ctrl with a ROM/palette model and a spec-level pixel model.
module tb_floor_render_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, pix_valid, frame_start, scroll_we, aux_req;
  logic [9:0] DrawX, DrawY, scroll_x, scroll_y, aux_addr, rom_addr;
  logic [3:0] rom_data, pal_index, pal_red, pal_green, pal_blue, red, green, blue, aux_data;
  logic       rgb_valid, aux_gnt, aux_data_valid;

  int total = 0;
  int bad   = 0;

  logic [3:0]  rom [1024];
  logic [11:0] pal [16];

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom[rom_addr];
  assign {pal_red, pal_green, pal_blue} = pal[pal_index];

  floor_render_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .pix_valid      (pix_valid),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .frame_start    (frame_start),
    .scroll_x       (scroll_x),
    .scroll_y       (scroll_y),
    .scroll_we      (scroll_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pal_index      (pal_index),
    .pal_red        (pal_red),
    .pal_green      (pal_green),
    .pal_blue       (pal_blue),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .rgb_valid      (rgb_valid),
    .aux_req        (aux_req),
    .aux_addr       (aux_addr),
    .aux_gnt        (aux_gnt),
    .aux_data_valid (aux_data_valid),
    .aux_data       (aux_data)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int model_addr(int x, int y, int sx, int sy);
    return ((y + sy) % 32) * 32 + ((x + sx) % 32);
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, int sx, int sy);
`ifdef FLOOR_GRID_EN
    if (((x + sx) % 32) == 0 || ((y + sy) % 32) == 0) return 12'hFFF;
`endif
    return pal[rom[model_addr(x, y, sx, sy)]];
  endfunction

  task automatic idle_inputs();
    pix_valid = 0; frame_start = 0; scroll_we = 0; aux_req = 0;
    DrawX = 0; DrawY = 0; scroll_x = 0; scroll_y = 0; aux_addr = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Reset = 1;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pix_valid = 1; DrawX = 7; DrawY = 9; aux_req = 1; aux_addr = 10'h2AA;
    Reset = 1;
    tick(); tick(); tick();
    total++;
    if ({rom_addr, red, green, blue, rgb_valid, aux_gnt, aux_data_valid, aux_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h rgb=%h%h%h v=%b gnt=%b dv=%b ad=%h, want all 0",
               rom_addr, red, green, blue, rgb_valid, aux_gnt, aux_data_valid, aux_data);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    pix_valid = 1; DrawX = 5; DrawY = 3;
    tick();
    pix_valid = 0;
    total++;
    if (rom_addr !== 10'd101) begin
      bad++; $display("FAIL basic_addr: got %0d want 101", rom_addr);
    end
    tick();
    total++;
    if (rgb_valid !== 1'b0) begin
      bad++; $display("FAIL basic_early_valid: got %b want 0", rgb_valid);
    end
    tick();
    total++;
    if (rgb_valid !== 1'b1 || {red, green, blue} !== model_rgb(5, 3, 0, 0)) begin
      bad++;
      $display("FAIL basic_rgb: got v=%b rgb=%h want v=1 rgb=%h", rgb_valid, {red, green, blue},
               model_rgb(5, 3, 0, 0));
    end
    tick();
    total++;
    if (rgb_valid !== 1'b0 || {red, green, blue} !== 12'h000) begin
      bad++; $display("FAIL basic_blank: got v=%b rgb=%h want v=0 rgb=000", rgb_valid,
                      {red, green, blue});
    end
  endtask

  task automatic test_scroll();
    scroll_we = 1; scroll_x = 40; scroll_y = 0;
    tick();
    scroll_we = 0; scroll_x = 0;
    pix_valid = 1; DrawX = 0; DrawY = 0;
    tick();
    total++;
    if (rom_addr !== 10'd0) begin
      bad++; $display("FAIL scroll_before_frame: got %0d want 0", rom_addr);
    end
    pix_valid = 0; frame_start = 1;
    tick();
    frame_start = 0; pix_valid = 1; DrawX = 0;
    tick();
    total++;
    if (rom_addr !== 10'd8) begin
      bad++; $display("FAIL scroll_after_frame: got %0d want 8", rom_addr);
    end
    DrawX = 639;
    tick();
    pix_valid = 0;
    total++;
    if (rom_addr !== 10'd7) begin
      bad++; $display("FAIL scroll_wrap_x: got %0d want 7", rom_addr);
    end
  endtask

  task automatic test_same_cycle();
    scroll_we = 1; frame_start = 1; scroll_x = 0; scroll_y = 33;
    tick();
    scroll_we = 0; frame_start = 0; scroll_y = 0;
    pix_valid = 1; DrawX = 0; DrawY = 0;
    tick();
    pix_valid = 0;
    total++;
    if (rom_addr !== 10'd32) begin
      bad++; $display("FAIL same_cycle_addr: got %0d want 32", rom_addr);
    end
    tick(); tick();
    total++;
    if (rgb_valid !== 1'b1 || {red, green, blue} !== model_rgb(0, 0, 0, 33)) begin
      bad++; $display("FAIL same_cycle_rgb: got v=%b rgb=%h want v=1 rgb=%h", rgb_valid,
                      {red, green, blue}, model_rgb(0, 0, 0, 33));
    end
  endtask

  task automatic test_aux_priority();
    apply_reset();
    pix_valid = 1; DrawX = 1; DrawY = 2; aux_req = 1; aux_addr = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (aux_gnt !== 1'b0 || rom_addr !== 10'd65) begin
        bad++; $display("FAIL aux_blocked: got gnt=%b addr=%0d want gnt=0 addr=65", aux_gnt,
                        rom_addr);
      end
    end
    pix_valid = 0;
    tick();
    total++;
    if (aux_gnt !== 1'b1 || rom_addr !== 10'h3FF) begin
      bad++; $display("FAIL aux_grant: got gnt=%b addr=%h want gnt=1 addr=3ff", aux_gnt, rom_addr);
    end
    aux_req = 0;
    tick();
    total++;
    if (aux_gnt !== 1'b0 || aux_data_valid !== 1'b0) begin
      bad++; $display("FAIL aux_wait: got gnt=%b dv=%b want 0 0", aux_gnt, aux_data_valid);
    end
    tick();
    total++;
    if (aux_data_valid !== 1'b1 || aux_data !== rom[10'h3FF]) begin
      bad++; $display("FAIL aux_data: got dv=%b data=%h want dv=1 data=%h", aux_data_valid,
                      aux_data, rom[10'h3FF]);
    end
    tick();
    total++;
    if (aux_data_valid !== 1'b0) begin
      bad++; $display("FAIL aux_dv_pulse: got %b want 0", aux_data_valid);
    end
  endtask

  task automatic test_aux_reset();
    bit seen = 0;
    apply_reset();
    aux_req = 1; aux_addr = 10'h155;
    tick();
    total++;
    if (aux_gnt !== 1'b1) begin
      bad++; $display("FAIL aux_rst_grant: got %b want 1", aux_gnt);
    end
    Reset = 1;
    tick();
    Reset = 0;
    total++;
    if ({rom_addr, red, green, blue, rgb_valid, aux_gnt, aux_data_valid, aux_data} !== '0) begin
      bad++; $display("FAIL aux_rst_outputs: got addr=%h gnt=%b dv=%b ad=%h, want all 0",
                      rom_addr, aux_gnt, aux_data_valid, aux_data);
    end
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (aux_gnt === 1'b1) seen = 1;
      else if (aux_data_valid !== 1'b0) begin
        total++; bad++;
        $display("FAIL aux_rst_dropped: got dv=%b want 0 before regrant", aux_data_valid);
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL aux_regrant: got gnt=0 want 1 within 6 cycles");
    end
    aux_req = 0;
    tick(); tick();
    total++;
    if (aux_data_valid !== 1'b1 || aux_data !== rom[10'h155]) begin
      bad++; $display("FAIL aux_regrant_data: got dv=%b data=%h want dv=1 data=%h",
                      aux_data_valid, aux_data, rom[10'h155]);
    end
  endtask

  task automatic test_grid();
    apply_reset();
    pix_valid = 1; DrawX = 32; DrawY = 1;
    tick();
    DrawX = 33;
    tick();
    pix_valid = 0;
    tick();
    total++;
    if (rgb_valid !== 1'b1 || {red, green, blue} !== model_rgb(32, 1, 0, 0)) begin
      bad++; $display("FAIL grid_x32: got v=%b rgb=%h want v=1 rgb=%h", rgb_valid,
                      {red, green, blue}, model_rgb(32, 1, 0, 0));
    end
    tick();
    total++;
    if (rgb_valid !== 1'b1 || {red, green, blue} !== model_rgb(33, 1, 0, 0)) begin
      bad++; $display("FAIL grid_x33: got v=%b rgb=%h want v=1 rgb=%h", rgb_valid,
                      {red, green, blue}, model_rgb(33, 1, 0, 0));
    end
  endtask

  task automatic test_random_stream();
    int sxp = 0, syp = 0, sxa = 0, sya = 0;
    logic        exp_v [$];
    logic [11:0] exp_c [$];
    logic        ev;
    logic [11:0] ec;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      pix_valid   = ($urandom_range(0, 3) != 0);
      DrawX       = 10'($urandom_range(0, 1023));
      DrawY       = 10'($urandom_range(0, 1023));
      scroll_we   = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 15) == 0);
      scroll_x    = 10'($urandom_range(0, 1023));
      scroll_y    = 10'($urandom_range(0, 1023));
      exp_v.push_back(pix_valid);
      exp_c.push_back(pix_valid ? model_rgb(int'(DrawX), int'(DrawY), sxa, sya) : 12'h000);
      if (scroll_we) begin sxp = int'(scroll_x); syp = int'(scroll_y); end
      if (frame_start) begin sxa = sxp; sya = syp; end
      tick();
      if (exp_v.size() == 3) begin
        ev = exp_v.pop_front();
        ec = exp_c.pop_front();
        total++;
        if (rgb_valid !== ev || {red, green, blue} !== ec) begin
          bad++; $display("FAIL stream[%0d]: got v=%b rgb=%h want v=%b rgb=%h", n, rgb_valid,
                          {red, green, blue}, ev, ec);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom);
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
    Reset = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_scroll();
    test_same_cycle();
    test_aux_priority();
    test_aux_reset();
    test_grid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/floor_render_ctrl.md
Name: floor_render_ctrl

Overview:
Sequences the floor-tile ROM and the 16-entry floor colour lookup to produce per-pixel floor RGB for the VGA path.
- Turns DrawX/DrawY plus a frame-latched scroll offset into a tile ROM address.
- Forwards the returned 4-bit index to the palette lookup and registers the resulting RGB.
- Arbitrates the single-port tile ROM between the video pipeline (absolute priority) and one auxiliary requester (minimap/debug readback), which is served only outside active video.

Parameters:
TILE_W, 32, tile width in pixels; power of two.
TILE_H, 32, tile height in pixels; power of two.
ROM_AW, 10, tile ROM address width; equals log2(TILE_W*TILE_H).

Ports:
Clk  in  1  system/pixel clock
Reset  in  1  synchronous, active-high reset
pix_valid  in  1  DrawX/DrawY are in the active display area this cycle
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
frame_start  in  1  one-cycle pulse at start of vertical blank
scroll_x  in  10  requested horizontal scroll
scroll_y  in  10  requested vertical scroll
scroll_we  in  1  load scroll_x/scroll_y into pending registers
rom_addr  out  ROM_AW  tile ROM address (registered)
rom_data  in  4  tile ROM index; synchronous ROM, 1-cycle latency
pal_index  out  4  index to palette lookup; combinational from rom_data
pal_red, pal_green, pal_blue  in  4 each  palette lookup result; combinational
red, green, blue  out  4 each  floor colour (registered)
rgb_valid  out  1  red/green/blue belong to an active pixel
aux_req  in  1  auxiliary ROM read request; level, held until aux_gnt
aux_addr  in  ROM_AW  auxiliary read address
aux_gnt  out  1  one-cycle pulse: aux_addr accepted
aux_data_valid  out  1  one-cycle pulse: aux_data valid
aux_data  out  4  auxiliary read result (registered)

Behaviour:
- Reset: rom_addr=0, red/green/blue=0, rgb_valid=0, aux_gnt=0, aux_data_valid=0, aux_data=0, pending and active scroll=0, aux FSM=IDLE, pipeline valid bits cleared. An in-flight aux read is dropped; no aux_data_valid is produced for it.
- Scroll:
  - scroll_we writes the pending registers.
  - frame_start copies pending to active.
  - If scroll_we and frame_start occur in the same cycle, the new inputs go to both pending and active.
  - Active scroll never changes mid-frame.
- Address: tx=(DrawX+scroll_x_act) mod TILE_W and ty=(DrawY+scroll_y_act) mod TILE_H, taken from the low bits so wrap is implicit. Address = ty*TILE_W+tx.
- Video pipeline, for input at cycle T with pix_valid=1:
  - T+1: rom_addr = video address.
  - T+2: rom_data valid, pal_index=rom_data.
  - T+3: red/green/blue = pal_* registered, rgb_valid=1.
  - Fixed latency is 3 cycles. rgb_valid is pix_valid delayed 3 cycles. When the delayed valid bit is 0, red/green/blue are forced to 0.
- Aux FSM states: IDLE, WAIT, RESP.
  - IDLE→WAIT when aux_req=1 and pix_valid=0 in the same cycle. aux_gnt pulses that cycle and rom_addr<=aux_addr.
  - WAIT→RESP unconditionally; the ROM is returning data.
  - RESP: aux_data<=rom_data, aux_data_valid=1 for one cycle, then →IDLE.
  - Grants are therefore at most one per 3 cycles.
  - If pix_valid=1, aux_req is ignored and rom_addr follows video.
  - pix_valid rising while in WAIT/RESP has no effect on the aux result, because the ROM slot was taken in the grant cycle.
- Idle ROM: when neither video nor aux drives it, rom_addr holds its value.

Optional Feature:
FLOOR_GRID_EN:
- Defined: pixels with tx==0 or ty==0 output 4'hF on all channels at stage T+3, giving a tile-boundary debug grid. Latency and valid timing are unchanged.
- Undefined: no grid logic; output is always the palette value.

Decomposition:
- Package floor_pkg holds:
  - TILE_W/TILE_H defaults
  - typedef rgb12_t (three 4-bit channels)
  - typedef aux_state_t enum {IDLE, WAIT, RESP}
  - the pipeline latency constant FLOOR_LAT=3
- One natural sub-module, floor_pixel_pipe: address arithmetic, valid shift register and RGB output register.
- The aux FSM and ROM address mux stay in the top.

Test Plan:
- Reset, then pix_valid=1, DrawX=5, DrawY=3, scroll=0 → rom_addr=101 at T+1; rgb_valid=1 at T+3 with the palette colour of the ROM index.
- scroll_we with scroll_x=40, scroll_y=0 mid-frame:
  - before frame_start, DrawX=0 → address 0
  - after frame_start → address 8 (40 mod 32)
  - DrawX=639 → tx=(679 mod 32)=7
- scroll_we and frame_start in the same cycle with scroll_y=33 → the next pixel DrawY=0 uses ty=1.
- aux_req=1, aux_addr=0x3FF during pix_valid=1 → no aux_gnt. When pix_valid drops: aux_gnt that cycle, aux_data_valid 2 cycles later with the ROM word at 0x3FF.
- Reset asserted in the WAIT state → aux_data_valid never pulses, all outputs 0 next cycle. aux_req still high after reset → re-granted when pix_valid=0.
- FLOOR_GRID_EN defined, DrawX=32, scroll=0 → output 12'hFFF at T+3. DrawX=33 → palette colour.
